// File: rtl/mem_stage.sv
// Memory-access pipeline stage sitting between EX and WB.
// It registers the EX payload and extracts load data from the synchronous data SRAM.
// SRAM read data is only valid in an instruction's first MEM cycle, so that word is
// buffered here and replayed while WB is stalled.
// The stage also drives the MEM bypass to decode and the exception-in-flight flag to EX.
module mem_stage #(
    parameter int XLEN      = 32,
    parameter int CSR_NUM_W = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_to_mem_valid,
    input  logic [XLEN-1:0]      ex_pc,
    input  logic [3:0]           ex_rf_we,
    input  logic [4:0]           ex_rf_waddr,
    input  logic [XLEN-1:0]      ex_alu_result,
    input  logic                 ex_res_from_mem,
    input  logic [2:0]           ex_load_op,
    input  logic                 ex_csr_we,
    input  logic [CSR_NUM_W-1:0] ex_csr_num,
    input  logic [XLEN-1:0]      ex_csr_wdata,
    input  logic [4:0]           ex_csr_wmask,
    input  logic                 ex_ertn,
    input  logic                 ex_syscall,
    input  logic [14:0]          ex_syscall_code,
    input  logic [XLEN-1:0]      data_sram_rdata,
    input  logic                 wb_allow_in,
    input  logic                 flush,
    output logic                 mem_allow_in,
    output logic                 to_wb_valid,
    output logic [XLEN-1:0]      pc,
    output logic [3:0]           rf_we,
    output logic [4:0]           rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 csr_we,
    output logic [CSR_NUM_W-1:0] csr_num,
    output logic [XLEN-1:0]      csr_wdata,
    output logic [4:0]           csr_wmask,
    output logic                 ertn,
    output logic                 syscall,
    output logic [14:0]          syscall_code,
    output logic                 mem_fwd_we,
    output logic [4:0]           mem_fwd_waddr,
    output logic [XLEN-1:0]      mem_fwd_wdata,
    output logic                 mem_ex_pending
);

    // Load-width select: ld.b/ld.bu pick a byte by addr[1:0], ld.h/ld.hu a half by addr[1].
    function automatic logic [XLEN-1:0] load_extract(input logic [2:0]      op,
                                                     input logic [1:0]      addr,
                                                     input logic [XLEN-1:0] word);
        logic [7:0]         byte_u;
        logic [15:0]        half_u;
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        case (addr)
            2'd0:    byte_u = word[7:0];
            2'd1:    byte_u = word[15:8];
            2'd2:    byte_u = word[23:16];
            default: byte_u = word[31:24];
        endcase
        half_u = addr[1] ? word[31:16] : word[15:0];
        byte_s = $signed(byte_u);
        half_s = $signed(half_u);
        case (op)
            3'b001:  load_extract = XLEN'(byte_s);
            3'b010:  load_extract = XLEN'(half_s);
            3'b011:  load_extract = XLEN'(byte_u);
            3'b100:  load_extract = XLEN'(half_u);
            default: load_extract = word;
        endcase
    endfunction

    logic                 vld_p1;
    logic                 held_p1;
    logic [XLEN-1:0]      rdata_buf_p1;
    logic [XLEN-1:0]      pc_p1;
    logic [3:0]           rf_we_p1;
    logic [4:0]           rf_waddr_p1;
    logic [XLEN-1:0]      alu_p1;
    logic                 res_from_mem_p1;
    logic [2:0]           load_op_p1;
    logic                 csr_we_p1;
    logic [CSR_NUM_W-1:0] csr_num_p1;
    logic [XLEN-1:0]      csr_wdata_p1;
    logic [4:0]           csr_wmask_p1;
    logic                 ertn_p1;
    logic                 syscall_p1;
    logic [14:0]          syscall_code_p1;
    logic [XLEN-1:0]      load_src;

    // ---- EX -> MEM boundary ----
    assign mem_allow_in = !vld_p1 || wb_allow_in;

    // Valid bit and read-buffer occupancy; flush kills the stage ahead of any advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1  <= 1'b0;
            held_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1  <= 1'b0;
            held_p1 <= 1'b0;
        end else begin
            if (mem_allow_in) vld_p1 <= ex_to_mem_valid;
            if (vld_p1 && wb_allow_in) held_p1 <= 1'b0;
            else if (vld_p1)           held_p1 <= 1'b1;
        end
    end

    // Capture the SRAM word in the instruction's first MEM cycle, before it goes stale.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 rdata_buf_p1 <= '0;
        else if (vld_p1 && !held_p1) rdata_buf_p1 <= data_sram_rdata;
    end

    // Payload register; a flush blocks the load so the dropped EX instruction never lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_p1           <= '0;
            rf_we_p1        <= '0;
            rf_waddr_p1     <= '0;
            alu_p1          <= '0;
            res_from_mem_p1 <= 1'b0;
            load_op_p1      <= '0;
            csr_we_p1       <= 1'b0;
            csr_num_p1      <= '0;
            csr_wdata_p1    <= '0;
            csr_wmask_p1    <= '0;
            ertn_p1         <= 1'b0;
            syscall_p1      <= 1'b0;
            syscall_code_p1 <= '0;
        end else if (!flush && mem_allow_in && ex_to_mem_valid) begin
            pc_p1           <= ex_pc;
            rf_we_p1        <= ex_rf_we;
            rf_waddr_p1     <= ex_rf_waddr;
            alu_p1          <= ex_alu_result;
            res_from_mem_p1 <= ex_res_from_mem;
            load_op_p1      <= ex_load_op;
            csr_we_p1       <= ex_csr_we;
            csr_num_p1      <= ex_csr_num;
            csr_wdata_p1    <= ex_csr_wdata;
            csr_wmask_p1    <= ex_csr_wmask;
            ertn_p1         <= ex_ertn;
            syscall_p1      <= ex_syscall;
            syscall_code_p1 <= ex_syscall_code;
        end
    end

    // ---- MEM -> WB boundary ----
    assign load_src     = held_p1 ? rdata_buf_p1 : data_sram_rdata;
    assign rf_wdata     = res_from_mem_p1 ? load_extract(load_op_p1, alu_p1[1:0], load_src)
                                          : alu_p1;
    assign to_wb_valid  = vld_p1 && !flush;
    assign pc           = pc_p1;
    assign rf_we        = rf_we_p1;
    assign rf_waddr     = rf_waddr_p1;
    assign csr_we       = csr_we_p1;
    assign csr_num      = csr_num_p1;
    assign csr_wdata    = csr_wdata_p1;
    assign csr_wmask    = csr_wmask_p1;
    assign ertn         = ertn_p1;
    assign syscall      = syscall_p1;
    assign syscall_code = syscall_code_p1;

    assign mem_fwd_we     = vld_p1 && (|rf_we_p1);
    assign mem_fwd_waddr  = rf_waddr_p1;
    assign mem_fwd_wdata  = rf_wdata;
    assign mem_ex_pending = vld_p1 && (syscall_p1 || ertn_p1);

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios followed by randomized traffic
// checked against a transaction-level model of the stage.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_to_mem_valid;
    logic [31:0] ex_pc;
    logic [3:0]  ex_rf_we;
    logic [4:0]  ex_rf_waddr;
    logic [31:0] ex_alu_result;
    logic        ex_res_from_mem;
    logic [2:0]  ex_load_op;
    logic        ex_csr_we;
    logic [13:0] ex_csr_num;
    logic [31:0] ex_csr_wdata;
    logic [4:0]  ex_csr_wmask;
    logic        ex_ertn;
    logic        ex_syscall;
    logic [14:0] ex_syscall_code;
    logic [31:0] data_sram_rdata;
    logic        wb_allow_in;
    logic        flush;
    logic        mem_allow_in;
    logic        to_wb_valid;
    logic [31:0] pc;
    logic [3:0]  rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wdata;
    logic [4:0]  csr_wmask;
    logic        ertn;
    logic        syscall;
    logic [14:0] syscall_code;
    logic        mem_fwd_we;
    logic [4:0]  mem_fwd_waddr;
    logic [31:0] mem_fwd_wdata;
    logic        mem_ex_pending;

    int total = 0;
    int bad   = 0;

    mem_stage #(.XLEN(32), .CSR_NUM_W(14)) dut (
        .clk(clk), .reset(reset),
        .ex_to_mem_valid(ex_to_mem_valid), .ex_pc(ex_pc), .ex_rf_we(ex_rf_we),
        .ex_rf_waddr(ex_rf_waddr), .ex_alu_result(ex_alu_result),
        .ex_res_from_mem(ex_res_from_mem), .ex_load_op(ex_load_op),
        .ex_csr_we(ex_csr_we), .ex_csr_num(ex_csr_num), .ex_csr_wdata(ex_csr_wdata),
        .ex_csr_wmask(ex_csr_wmask), .ex_ertn(ex_ertn), .ex_syscall(ex_syscall),
        .ex_syscall_code(ex_syscall_code), .data_sram_rdata(data_sram_rdata),
        .wb_allow_in(wb_allow_in), .flush(flush),
        .mem_allow_in(mem_allow_in), .to_wb_valid(to_wb_valid), .pc(pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_we(csr_we), .csr_num(csr_num), .csr_wdata(csr_wdata), .csr_wmask(csr_wmask),
        .ertn(ertn), .syscall(syscall), .syscall_code(syscall_code),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_waddr(mem_fwd_waddr),
        .mem_fwd_wdata(mem_fwd_wdata), .mem_ex_pending(mem_ex_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] p, input logic [3:0] we,
                            input logic [4:0] wa, input logic [31:0] alu, input logic rfm,
                            input logic [2:0] op, input logic sys, input logic er);
        ex_to_mem_valid = v;   ex_pc = p;            ex_rf_we = we;
        ex_rf_waddr = wa;      ex_alu_result = alu;  ex_res_from_mem = rfm;
        ex_load_op = op;       ex_syscall = sys;     ex_ertn = er;
        ex_csr_we = 1'b0;      ex_csr_num = '0;      ex_csr_wdata = '0;
        ex_csr_wmask = '0;     ex_syscall_code = sys ? 15'h0B : 15'h0;
    endtask

    // Reference load extraction, computed with shifts, masks and two's-complement arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] w);
        longint unsigned b, h;
        b = (longint'(w) >> (8 * a)) & 64'd255;
        h = (longint'(w) >> (16 * (a / 2))) & 64'd65535;
        case (op)
            3'b001:  return (b >= 128) ? 32'(b - 64'd256) : 32'(b);
            3'b011:  return 32'(b);
            3'b010:  return (h >= 32768) ? 32'(h - 64'd65536) : 32'(h);
            3'b100:  return 32'(h);
            default: return w;
        endcase
    endfunction

    // Transaction-level model: the instruction occupying MEM, its age and its first-cycle word.
    typedef struct {
        logic [31:0] pc;
        logic [3:0]  we;
        logic [4:0]  wa;
        logic [31:0] alu;
        logic        rfm;
        logic [2:0]  op;
        logic        sys;
        logic        er;
        logic [31:0] csr_wdata;
    } instr_t;

    logic        m_occ;
    int          m_age;
    logic [31:0] m_word;
    instr_t      m_ins;
    logic [31:0] e_wdata;
    logic [31:0] e_src;

    initial begin
        reset = 1'b0;
        drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        data_sram_rdata = '0;
        wb_allow_in = 1'b1;
        flush = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_to_wb_valid", 32'(to_wb_valid), 0);
        check("rst_mem_allow_in", 32'(mem_allow_in), 1);
        check("rst_fwd_we", 32'(mem_fwd_we), 0);
        check("rst_ex_pending", 32'(mem_ex_pending), 0);
        check("rst_pc", pc, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        tick();
        reset = 1'b1;

        // Load extraction.
        drive_ex(1, 32'h100, 4'hF, 5'd1, 32'h1003, 1, 3'b001, 0, 0);
        tick();
        data_sram_rdata = 32'h80FF_1234;
        drive_ex(1, 32'h104, 4'hF, 5'd1, 32'h1003, 1, 3'b011, 0, 0);
        @(negedge clk);
        check("ld_b_valid", 32'(to_wb_valid), 1);
        check("ld_b", rf_wdata, 32'hFFFF_FF80);
        tick();
        drive_ex(1, 32'h108, 4'hF, 5'd1, 32'h1002, 1, 3'b100, 0, 0);
        @(negedge clk);
        check("ld_bu", rf_wdata, 32'h0000_0080);
        tick();
        drive_ex(1, 32'h10C, 4'hF, 5'd1, 32'h1002, 1, 3'b010, 0, 0);
        @(negedge clk);
        check("ld_hu", rf_wdata, 32'h0000_80FF);
        tick();
        drive_ex(1, 32'h110, 4'hF, 5'd1, 32'h1000, 1, 3'b000, 0, 0);
        @(negedge clk);
        check("ld_h", rf_wdata, 32'hFFFF_80FF);
        tick();
        drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("ld_w", rf_wdata, 32'h80FF_1234);
        check("ld_w_pc", pc, 32'h110);
        tick();
        @(negedge clk);
        check("ld_drain_valid", 32'(to_wb_valid), 0);

        // Stall with stale SRAM data.
        drive_ex(1, 32'h200, 4'hF, 5'd2, 32'h2000, 1, 3'b000, 0, 0);
        tick();
        drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        data_sram_rdata = 32'hDEAD_BEEF;
        wb_allow_in = 1'b0;
        @(negedge clk);
        check("stall_first_wdata", rf_wdata, 32'hDEAD_BEEF);
        check("stall_allow_in", 32'(mem_allow_in), 0);
        tick();
        data_sram_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_held_wdata", rf_wdata, 32'hDEAD_BEEF);
            check("stall_held_valid", 32'(to_wb_valid), 1);
            tick();
        end
        wb_allow_in = 1'b1;
        @(negedge clk);
        check("stall_release_wdata", rf_wdata, 32'hDEAD_BEEF);
        check("stall_release_pc", pc, 32'h200);
        check("stall_release_allow", 32'(mem_allow_in), 1);
        tick();
        @(negedge clk);
        check("stall_gone_valid", 32'(to_wb_valid), 0);

        // Back-to-back ALU instructions.
        drive_ex(1, 32'h300, 4'hF, 5'd3, 32'h7, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive_ex(1, 32'h300 + 32'(4 * (i + 1)), 4'hF, 5'd3, 32'h7, 0, 0, 0, 0);
            else       drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            check("b2b_valid", 32'(to_wb_valid), 1);
            check("b2b_pc", pc, 32'h300 + 32'(4 * i));
            tick();
        end
        @(negedge clk);
        check("b2b_end_valid", 32'(to_wb_valid), 0);

        // Bypass.
        drive_ex(1, 32'h500, 4'hF, 5'd5, 32'h10, 0, 0, 0, 0);
        tick();
        drive_ex(1, 32'h504, 4'h0, 5'd6, 32'h20, 0, 0, 0, 0);
        @(negedge clk);
        check("fwd_we", 32'(mem_fwd_we), 1);
        check("fwd_waddr", 32'(mem_fwd_waddr), 5);
        check("fwd_wdata", mem_fwd_wdata, 32'h10);
        tick();
        drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("fwd_we_off", 32'(mem_fwd_we), 0);
        check("fwd_off_valid", 32'(to_wb_valid), 1);
        tick();

        // Flush against a syscall in MEM with a new EX instruction arriving.
        drive_ex(1, 32'h400, 4'h0, 5'd0, 32'h0, 0, 0, 1, 0);
        tick();
        drive_ex(1, 32'h404, 4'hF, 5'd4, 32'h44, 0, 0, 0, 0);
        flush = 1'b1;
        @(negedge clk);
        check("flush_pending", 32'(mem_ex_pending), 1);
        check("flush_to_wb_gated", 32'(to_wb_valid), 0);
        check("flush_syscall_code", 32'(syscall_code), 32'h0B);
        tick();
        flush = 1'b0;
        drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("flush_next_valid", 32'(to_wb_valid), 0);
        check("flush_next_pending", 32'(mem_ex_pending), 0);
        check("flush_next_allow", 32'(mem_allow_in), 1);
        check("flush_dropped_pc", pc, 32'h400);
        tick();

        // Asynchronous reset in the middle of a stall.
        drive_ex(1, 32'h600, 4'hF, 5'd7, 32'h3000, 1, 3'b000, 0, 0);
        tick();
        drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb_allow_in = 1'b0;
        data_sram_rdata = 32'h1234_5678;
        @(negedge clk);
        check("rstst_pre_valid", 32'(to_wb_valid), 1);
        check("rstst_pre_allow", 32'(mem_allow_in), 0);
        #1 reset = 1'b0;
        #1;
        check("rstst_to_wb_valid", 32'(to_wb_valid), 0);
        check("rstst_fwd_we", 32'(mem_fwd_we), 0);
        check("rstst_allow_in", 32'(mem_allow_in), 1);
        check("rstst_pc", pc, 0);
        tick();
        reset = 1'b1;
        wb_allow_in = 1'b1;

        // Randomized traffic against the model.
        m_occ = 1'b0;
        m_age = 0;
        m_word = '0;
        for (int n = 0; n < 400; n++) begin
            ex_to_mem_valid = ($urandom % 4) != 0;
            ex_pc           = $urandom;
            case ($urandom % 3)
                0:       ex_rf_we = 4'h0;
                1:       ex_rf_we = 4'hF;
                default: ex_rf_we = 4'($urandom);
            endcase
            ex_rf_waddr     = 5'($urandom);
            ex_alu_result   = $urandom;
            ex_res_from_mem = 1'($urandom);
            ex_load_op      = 3'($urandom % 5);
            ex_csr_we       = 1'($urandom);
            ex_csr_num      = 14'($urandom);
            ex_csr_wdata    = $urandom;
            ex_csr_wmask    = 5'($urandom);
            ex_syscall      = ($urandom % 8) == 0;
            ex_ertn         = ($urandom % 8) == 0;
            ex_syscall_code = 15'($urandom);
            wb_allow_in     = ($urandom % 3) != 0;
            flush           = ($urandom % 16) == 0;
            data_sram_rdata = $urandom;
            @(negedge clk);
            check("rnd_to_wb_valid", 32'(to_wb_valid), 32'(m_occ && !flush));
            check("rnd_allow_in", 32'(mem_allow_in), 32'(!m_occ || wb_allow_in));
            check("rnd_fwd_we", 32'(mem_fwd_we), 32'(m_occ && (m_ins.we != 4'h0)));
            check("rnd_ex_pending", 32'(mem_ex_pending), 32'(m_occ && (m_ins.sys || m_ins.er)));
            if (m_occ) begin
                e_src   = (m_age == 0) ? data_sram_rdata : m_word;
                e_wdata = m_ins.rfm ? ref_load(m_ins.op, m_ins.alu[1:0], e_src) : m_ins.alu;
                check("rnd_rf_wdata", rf_wdata, e_wdata);
                check("rnd_fwd_wdata", mem_fwd_wdata, e_wdata);
                check("rnd_pc", pc, m_ins.pc);
                check("rnd_rf_waddr", 32'(rf_waddr), 32'(m_ins.wa));
                check("rnd_csr_wdata", csr_wdata, m_ins.csr_wdata);
                if (m_age == 0) m_word = data_sram_rdata;
            end
            if (flush) begin
                m_occ = 1'b0;
            end else if (!m_occ || wb_allow_in) begin
                m_occ = ex_to_mem_valid;
                if (ex_to_mem_valid) begin
                    m_ins.pc = ex_pc;            m_ins.we = ex_rf_we;
                    m_ins.wa = ex_rf_waddr;      m_ins.alu = ex_alu_result;
                    m_ins.rfm = ex_res_from_mem; m_ins.op = ex_load_op;
                    m_ins.sys = ex_syscall;      m_ins.er = ex_ertn;
                    m_ins.csr_wdata = ex_csr_wdata;
                    m_age = 0;
                end
            end else begin
                m_age++;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
